ibex_multdiv_arbiter: RTL and testbench
=======================================

# ibex_multdiv_arbiter

Sequencer and two-port arbiter for the shared slow multiplier/divider (Baugh-Wooley multiply, long division). It accepts MUL/DIV/REM requests from two requesters through valid/ready channels and grants them round-robin. It holds the unit's enables, selects, operator and operands stable for the whole operation, and captures the result through the unit's ready handshake. It returns the result to the granted requester. The block sits between the requesters (e.g. core ID stage and a coprocessor port) and the multdiv unit.

## Interface
- No parameters; requester count fixed at 2, data width fixed at 32.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester request accept.
- req_operator_i  in  2x2  md_op_e per requester: MULL=0, MULH=1, DIV=2, REM=3.
- req_signed_mode_i  in  2x2  per requester; bit0 = op_a signed, bit1 = op_b signed.
- req_op_a_i, req_op_b_i  in  2x32  operands per requester.
- rsp_valid_o  out  2  result valid; at most one bit set.
- rsp_ready_i  in  2  per-requester result accept.
- rsp_result_o  out  32  shared result bus.
- data_ind_timing_i  in  1  data-independent-timing config; sampled at grant.
- md_mult_en_o, md_div_en_o  out  1  dynamic enables to the unit.
- md_mult_sel_o, md_div_sel_o  out  1  static selects to the unit.
- md_operator_o  out  2  operator to the unit.
- md_signed_mode_o  out  2  signed mode to the unit.
- md_op_a_o, md_op_b_o  out  32  operands to the unit.
- md_data_ind_timing_o  out  1  latched config to the unit.
- md_valid_i  in  1  unit result valid.
- md_result_i  in  32  unit result.
- md_ready_id_o  out  1  result-consumed handshake to the unit.
- busy_o  out  1  state != IDLE.
- grant_o  out  1  index of the current or last granted requester.

## Operation
- FSM states:
  - IDLE: req_ready_o = ~0; all md enables/selects are 0.
    - Arbitration: a single valid requester is granted. With both valid, requester `rr_q` is granted.
    - On grant of requester g: latch its operator, signed_mode, op_a, op_b and data_ind_timing_i. Set grant_q = g and rr_q = ~g. Go to BUSY.
  - BUSY:
    - mult_sel/mult_en = 1 iff operator is MULL or MULH; div_sel/div_en = 1 iff operator is DIV or REM. Exactly one pair is high.
    - md_ready_id_o = 1.
    - On md_valid_i: capture md_result_i into res_q and go to RESP. The unit returns to its idle state in the same edge.
  - RESP: enables/selects 0; md_ready_id_o = 0; rsp_valid_o[grant_q] = 1; rsp_result_o = res_q. On rsp_ready_i[grant_q], go to IDLE.
- Operand and operator outputs are driven from the latched registers only. They stay constant from BUSY entry until the next grant.
- rsp_result_o outside RESP = res_q, which is don't-care for the bench.
- rsp_ready_i of the non-granted requester is ignored.
- req_valid_i held during BUSY/RESP is not accepted and is not dropped; it competes at the next IDLE.
- Sync reset in any state: next state is IDLE, rr_q = 0, grant_q = 0, res_q = 0, and latched operands are 0.
  - The multdiv unit must be reset in the same cycle; this is a system-level requirement.
  - An in-flight result is discarded and no rsp_valid is issued.

## Timing
- Reset values:
  - req_ready_o = 2'b11 (IDLE).
  - rsp_valid_o = 0, rsp_result_o = 0.
  - All md_* outputs = 0.
  - busy_o = 0, grant_o = 0.
- Accept at edge T (valid&ready) gives BUSY at T+1; unit sees enables at T+1.
- The unit raises md_valid_i at cycle V and the result is captured at edge V. rsp_valid_o rises at V+1.
- Unit latencies, counted from T+1 as the unit's idle cycle:
  - MULL with op_b in {0,1}, non-DIT: V = T+2, giving rsp at T+3.
  - MULH: V = T+33, giving rsp at T+34.
  - DIV/REM full: V = T+37, giving rsp at T+38.
  - DIV/REM by zero, non-DIT: V = T+2, giving rsp at T+3.
  - DIV/REM by zero, DIT: full length.
- Response handshake at edge R gives IDLE at R+1. The earliest next grant is at edge R+1. Minimum request-to-request spacing is therefore latency+2.
- req_ready_o is combinational from state only; it does not depend on req_valid_i.

## Test plan
- Single MULL 7*6 from req0: accept at T -> rsp_valid_o = 2'b01 at T+4 (op_b 6 is not in {0,1}) with result 42. mult_en held T+1..V, div_en 0 throughout.
- Simultaneous requests after reset: req0 DIV 100/7, req1 REM 100/7.
  - req0 is granted first; result 14, rsp at T+38.
  - req1 is granted at R+1 with result 2.
  - rr_q then favours req0.
- DIV signed -7/0, non-DIT -> 0xFFFFFFFF at T+3. Same with data_ind_timing_i=1 -> 0xFFFFFFFF at T+38.
- MULH signed 0x80000000*0x80000000 -> 0x40000000 at T+34. Hold rsp_ready_i low 5 cycles -> rsp_valid_o stays high and the result is stable. req1 valid in the meantime is not accepted.
- Reset asserted mid-DIV (BUSY, cycle T+10) -> next cycle all outputs equal reset values. A new MULL 3*3 then completes with result 9.
- Back-to-back alternation: both requesters continuously valid with MULL 1*k -> grants alternate 0,1,0,1. Each response precedes the next grant.

Source files
------------

// File: rtl/ibex_multdiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_multdiv_arbiter
// Purpose  : Two-port round-robin arbiter and sequencer for the shared slow
//            multiplier/divider; holds operands stable and returns the result.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_multdiv_arbiter (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][1:0]  req_operator_i,
    input  logic [1:0][1:0]  req_signed_mode_i,
    input  logic [1:0][31:0] req_op_a_i,
    input  logic [1:0][31:0] req_op_b_i,

    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [31:0]      rsp_result_o,

    input  logic             data_ind_timing_i,

    output logic             md_mult_en_o,
    output logic             md_div_en_o,
    output logic             md_mult_sel_o,
    output logic             md_div_sel_o,
    output logic [1:0]       md_operator_o,
    output logic [1:0]       md_signed_mode_o,
    output logic [31:0]      md_op_a_o,
    output logic [31:0]      md_op_b_o,
    output logic             md_data_ind_timing_o,
    input  logic             md_valid_i,
    input  logic [31:0]      md_result_i,
    output logic             md_ready_id_o,

    output logic             busy_o,
    output logic             grant_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [1:0] c_OP_MULL = 2'd0;
    localparam logic [1:0] c_OP_MULH = 2'd1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_rr;
    logic        r_grant;
    logic        r_dit;
    logic [1:0]  r_operator;
    logic [1:0]  r_signed_mode;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_res;

    logic        w_accept;
    logic        w_grant_idx;
    logic        w_is_mul;

    // A lone requester always wins; on a tie the round-robin pointer decides.
    always_comb begin
        w_grant_idx = r_rr;
        if (req_valid_i == 2'b01) begin
            w_grant_idx = 1'b0;
        end else if (req_valid_i == 2'b10) begin
            w_grant_idx = 1'b1;
        end
    end

    assign w_accept = (r_state == c_IDLE) && (req_valid_i != 2'b00);
    assign w_is_mul = (r_operator == c_OP_MULL) || (r_operator == c_OP_MULH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_BUSY;
                end
            end
            c_BUSY: begin
                if (md_valid_i) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready_i[r_grant]) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Operands are only ever updated at a grant, so the unit sees them frozen
    // from BUSY entry until the next transaction is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr          <= 1'b0;
            r_grant       <= 1'b0;
            r_dit         <= 1'b0;
            r_operator    <= 2'b00;
            r_signed_mode <= 2'b00;
            r_op_a        <= 32'h0;
            r_op_b        <= 32'h0;
            r_res         <= 32'h0;
        end else begin
            if (w_accept) begin
                r_grant       <= w_grant_idx;
                r_rr          <= ~w_grant_idx;
                r_dit         <= data_ind_timing_i;
                r_operator    <= req_operator_i[w_grant_idx];
                r_signed_mode <= req_signed_mode_i[w_grant_idx];
                r_op_a        <= req_op_a_i[w_grant_idx];
                r_op_b        <= req_op_b_i[w_grant_idx];
            end
            if ((r_state == c_BUSY) && md_valid_i) begin
                r_res <= md_result_i;
            end
        end
    end

    always_comb begin
        req_ready_o   = 2'b00;
        rsp_valid_o   = 2'b00;
        md_mult_en_o  = 1'b0;
        md_mult_sel_o = 1'b0;
        md_div_en_o   = 1'b0;
        md_div_sel_o  = 1'b0;
        md_ready_id_o = 1'b0;
        case (r_state)
            c_IDLE: req_ready_o = 2'b11;
            c_BUSY: begin
                md_mult_en_o  = w_is_mul;
                md_mult_sel_o = w_is_mul;
                md_div_en_o   = ~w_is_mul;
                md_div_sel_o  = ~w_is_mul;
                md_ready_id_o = 1'b1;
            end
            c_RESP: rsp_valid_o[r_grant] = 1'b1;
            default: ;
        endcase
    end

    assign md_operator_o        = r_operator;
    assign md_signed_mode_o     = r_signed_mode;
    assign md_op_a_o            = r_op_a;
    assign md_op_b_o            = r_op_b;
    assign md_data_ind_timing_o = r_dit;
    assign rsp_result_o         = r_res;
    assign busy_o               = (r_state != c_IDLE);
    assign grant_o              = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_multdiv_arbiter
// Purpose  : Self-checking bench with a behavioural multdiv unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_multdiv_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][1:0]  req_operator_i;
    logic [1:0][1:0]  req_signed_mode_i;
    logic [1:0][31:0] req_op_a_i;
    logic [1:0][31:0] req_op_b_i;
    logic [1:0]       rsp_valid_o;
    logic [1:0]       rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic             data_ind_timing_i;
    logic             md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
    logic [1:0]       md_operator_o, md_signed_mode_o;
    logic [31:0]      md_op_a_o, md_op_b_o;
    logic             md_data_ind_timing_o;
    logic             md_valid_i;
    logic [31:0]      md_result_i;
    logic             md_ready_id_o, busy_o, grant_o;

    int n_tests = 0;
    int n_fail  = 0;
    int unit_cnt = 0;

    always #5 clk_i = ~clk_i;

    ibex_multdiv_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
        .data_ind_timing_i(data_ind_timing_i),
        .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
        .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
        .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
        .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
        .md_data_ind_timing_o(md_data_ind_timing_o),
        .md_valid_i(md_valid_i), .md_result_i(md_result_i),
        .md_ready_id_o(md_ready_id_o), .busy_o(busy_o), .grant_o(grant_o)
    );

    // Architectural result of a MUL/DIV/REM operation.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] sm,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] pa, pb, prod;
        pa   = sm[0] ? {{34{a[31]}}, a} : {34'b0, a};
        pb   = sm[1] ? {{34{b[31]}}, b} : {34'b0, b};
        prod = pa * pb;
        case (op)
            2'd0: return prod[31:0];
            2'd1: return prod[63:32];
            2'd2: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (sm == 2'b11) begin
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                    return $signed(a) / $signed(b);
                end
                return a / b;
            end
            default: begin
                if (b == 32'h0) return a;
                if (sm == 2'b11) begin
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                    return $signed(a) % $signed(b);
                end
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the unit's idle cycle (k=1) to the cycle it asserts valid.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b, input logic dit);
        case (op)
            2'd0:    return (!dit && b <= 32'd1) ? 2 : 3;
            2'd1:    return 33;
            default: return (!dit && b == 32'h0) ? 2 : 37;
        endcase
    endfunction

    always @(posedge clk_i) begin
        if (rst_i || !(md_mult_en_o || md_div_en_o)) unit_cnt <= 0;
        else unit_cnt <= unit_cnt + 1;
    end

    assign md_valid_i  = (md_mult_en_o || md_div_en_o) &&
                         (unit_cnt + 1 == ref_lat(md_operator_o, md_op_b_o, md_data_ind_timing_o));
    assign md_result_i = md_valid_i ? ref_result(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o)
                                    : (32'hDEAD0000 | 32'(unit_cnt));

    task automatic do_reset();
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic [1:0] op, input logic [1:0] sm,
                           input logic [31:0] a, input logic [31:0] b);
        req_operator_i[idx]    = op;
        req_signed_mode_i[idx] = sm;
        req_op_a_i[idx]        = a;
        req_op_b_i[idx]        = b;
    endtask

    // Called in the first cycle after the accepting edge; n is the cycle offset from T.
    task automatic wait_rsp(output int n);
        n = 1;
        while (rsp_valid_o == 2'b00 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic handshake(input int idx);
        rsp_ready_i[idx] = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (req_ready_o !== 2'b11) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=11", req_ready_o); end
        n_tests++; if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid_o); end
        n_tests++; if (rsp_result_o !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result_o); end
        n_tests++; if ({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_operator_o, md_signed_mode_o,
                        md_op_a_o, md_op_b_o, md_data_ind_timing_o, md_ready_id_o} !== '0) begin
            n_fail++; $display("FAIL reset_md_outputs got nonzero a=%h b=%h", md_op_a_o, md_op_b_o); end
        n_tests++; if ({busy_o, grant_o} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_grant got=%b exp=00", {busy_o, grant_o}); end
    endtask

    task automatic test_mull();
        int n; bit bad;
        bad = 0;
        set_req(0, 2'd0, 2'b00, 32'd7, 32'd6);
        data_ind_timing_i = 1'b0;
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        n_tests++; if ({busy_o, grant_o, req_ready_o, md_ready_id_o} !== 5'b10001) begin
            n_fail++; $display("FAIL mull_busy_entry got=%b exp=10001", {busy_o, grant_o, req_ready_o, md_ready_id_o}); end
        n_tests++; if ({md_op_a_o, md_op_b_o, md_operator_o} !== {32'd7, 32'd6, 2'd0}) begin
            n_fail++; $display("FAIL mull_operands got a=%0d b=%0d op=%0d", md_op_a_o, md_op_b_o, md_operator_o); end
        n = 1;
        while (rsp_valid_o == 2'b00 && n < 100) begin
            if (!md_mult_en_o || !md_mult_sel_o || md_div_en_o || md_div_sel_o) bad = 1;
            @(negedge clk_i);
            n++;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL mull_enables got=bad exp=mult_only"); end
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL mull_latency got=%0d exp=4", n); end
        n_tests++; if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd42) begin
            n_fail++; $display("FAIL mull_rsp got v=%b r=%0d exp v=01 r=42", rsp_valid_o, rsp_result_o); end
        n_tests++; if ({md_mult_en_o, md_div_en_o, md_ready_id_o} !== 3'b000) begin
            n_fail++; $display("FAIL mull_resp_md got=%b exp=000", {md_mult_en_o, md_div_en_o, md_ready_id_o}); end
        handshake(0);
        n_tests++; if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00) begin
            n_fail++; $display("FAIL mull_idle got busy=%b v=%b exp 0/00", busy_o, rsp_valid_o); end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        set_req(0, 2'd2, 2'b00, 32'd100, 32'd7);
        set_req(1, 2'd3, 2'b00, 32'd100, 32'd7);
        req_valid_i = 2'b11;
        @(negedge clk_i);
        req_valid_i[0] = 1'b0;
        n_tests++; if (grant_o !== 1'b0 || md_div_en_o !== 1'b1) begin
            n_fail++; $display("FAIL sim_first_grant got g=%b div=%b exp 0/1", grant_o, md_div_en_o); end
        wait_rsp(n);
        n_tests++; if (n != 38 || rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd14) begin
            n_fail++; $display("FAIL sim_div got n=%0d v=%b r=%0d exp 38/01/14", n, rsp_valid_o, rsp_result_o); end
        handshake(0);
        @(negedge clk_i);
        req_valid_i[1] = 1'b0;
        n_tests++; if (grant_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL sim_second_grant got g=%b busy=%b exp 1/1", grant_o, busy_o); end
        wait_rsp(n);
        n_tests++; if (n != 38 || rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd2) begin
            n_fail++; $display("FAIL sim_rem got n=%0d v=%b r=%0d exp 38/10/2", n, rsp_valid_o, rsp_result_o); end
        handshake(1);
        set_req(0, 2'd0, 2'b00, 32'd1, 32'd1);
        set_req(1, 2'd0, 2'b00, 32'd1, 32'd1);
        req_valid_i = 2'b11;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        n_tests++; if (grant_o !== 1'b0) begin n_fail++; $display("FAIL sim_rr_after got=%b exp=0", grant_o); end
        wait_rsp(n);
        handshake(0);
    endtask

    task automatic test_div_zero();
        int n;
        set_req(0, 2'd2, 2'b11, 32'hFFFFFFF9, 32'd0);
        data_ind_timing_i = 1'b0;
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        data_ind_timing_i = 1'b1;
        n_tests++; if (md_data_ind_timing_o !== 1'b0) begin n_fail++; $display("FAIL divz_dit_latch got=1 exp=0"); end
        wait_rsp(n);
        n_tests++; if (n != 3 || rsp_result_o !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL divz_fast got n=%0d r=%h exp 3/ffffffff", n, rsp_result_o); end
        handshake(0);
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        data_ind_timing_i = 1'b0;
        n_tests++; if (md_data_ind_timing_o !== 1'b1) begin n_fail++; $display("FAIL divz_dit_set got=0 exp=1"); end
        wait_rsp(n);
        n_tests++; if (n != 38 || rsp_result_o !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL divz_dit got n=%0d r=%h exp 38/ffffffff", n, rsp_result_o); end
        handshake(0);
    endtask

    task automatic test_mulh_hold();
        int n; bit bad;
        bad = 0;
        set_req(0, 2'd1, 2'b11, 32'h80000000, 32'h80000000);
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b10;
        set_req(1, 2'd0, 2'b00, 32'd5, 32'd5);
        wait_rsp(n);
        n_tests++; if (n != 34 || rsp_valid_o !== 2'b01 || rsp_result_o !== 32'h40000000) begin
            n_fail++; $display("FAIL mulh got n=%0d v=%b r=%h exp 34/01/40000000", n, rsp_valid_o, rsp_result_o); end
        rsp_ready_i[1] = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'h40000000 || grant_o !== 1'b0 ||
                md_op_a_o !== 32'h80000000) bad = 1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL mulh_hold got=unstable exp=stable"); end
        rsp_ready_i = 2'b01;
        @(negedge clk_i);
        rsp_ready_i = 2'b00;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        n_tests++; if (grant_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL mulh_pending_grant got g=%b busy=%b exp 1/1", grant_o, busy_o); end
        wait_rsp(n);
        n_tests++; if (n != 4 || rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd25) begin
            n_fail++; $display("FAIL mulh_pending_rsp got n=%0d v=%b r=%0d exp 4/10/25", n, rsp_valid_o, rsp_result_o); end
        handshake(1);
    endtask

    task automatic test_reset_mid();
        int n; bit bad;
        bad = 0;
        set_req(1, 2'd2, 2'b11, 32'd1000, 32'd3);
        req_valid_i = 2'b10;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        n_tests++; if ({req_ready_o, rsp_valid_o, busy_o, grant_o, md_mult_en_o, md_div_en_o, md_mult_sel_o,
                        md_div_sel_o, md_operator_o, md_signed_mode_o, md_data_ind_timing_o, md_ready_id_o} !== 16'hC000 ||
                       {rsp_result_o, md_op_a_o, md_op_b_o} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs got busy=%b g=%b a=%h b=%h exp reset values", busy_o, grant_o, md_op_a_o, md_op_b_o); end
        rst_i = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) bad = 1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL rstmid_no_rsp got=activity exp=idle"); end
        set_req(0, 2'd0, 2'b00, 32'd3, 32'd3);
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        wait_rsp(n);
        n_tests++; if (n != 4 || rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd9) begin
            n_fail++; $display("FAIL rstmid_mull got n=%0d v=%b r=%0d exp 4/01/9", n, rsp_valid_o, rsp_result_o); end
        handshake(0);
    endtask

    task automatic test_back_to_back();
        int n; int g; logic [31:0] k [2];
        do_reset();
        k[0] = 32'd2;
        k[1] = 32'd100;
        set_req(0, 2'd0, 2'b00, 32'd1, k[0]);
        set_req(1, 2'd0, 2'b00, 32'd1, k[1]);
        req_valid_i = 2'b11;
        for (int i = 0; i < 6; i++) begin
            g = i % 2;
            @(negedge clk_i);
            n_tests++; if (grant_o !== 1'(g) || busy_o !== 1'b1 || md_op_b_o !== k[g]) begin
                n_fail++; $display("FAIL b2b_grant%0d got g=%b b=%0d exp g=%0d b=%0d", i, grant_o, md_op_b_o, g, k[g]); end
            k[g] = k[g] + 32'd1;
            req_op_b_i[g] = k[g];
            wait_rsp(n);
            n_tests++; if (n != 4 || rsp_valid_o !== 2'(1 << g) || rsp_result_o !== k[g] - 32'd1) begin
                n_fail++; $display("FAIL b2b_rsp%0d got n=%0d v=%b r=%0d exp r=%0d", i, n, rsp_valid_o, rsp_result_o, k[g] - 32'd1); end
            handshake(g);
            n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle%0d got=1 exp=0", i); end
        end
        req_valid_i = 2'b00;
        do_reset();
    endtask

    task automatic test_random();
        bit pend [2];
        logic [1:0] p_op [2], p_sm [2];
        logic [31:0] p_a [2], p_b [2];
        int last_g, g, n;
        logic dit;
        do_reset();
        last_g = 1;
        pend[0] = 0;
        pend[1] = 0;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1 || (i == 1 && !pend[0]))) begin
                    p_op[i] = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0: p_b[i] = 32'd0;
                        1: p_b[i] = 32'd1;
                        2: p_b[i] = 32'($urandom_range(2, 20));
                        default: p_b[i] = $urandom;
                    endcase
                    p_a[i] = $urandom;
                    if (p_op[i][1]) p_sm[i] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                    else p_sm[i] = 2'($urandom_range(0, 3));
                    set_req(i, p_op[i], p_sm[i], p_a[i], p_b[i]);
                    pend[i] = 1;
                    req_valid_i[i] = 1'b1;
                end
            end
            dit = 1'($urandom_range(0, 1));
            data_ind_timing_i = dit;
            if (pend[0] && pend[1]) g = (last_g == 0) ? 1 : 0;
            else g = pend[0] ? 0 : 1;
            @(negedge clk_i);
            data_ind_timing_i = ~dit;
            n_tests++; if (grant_o !== 1'(g) || busy_o !== 1'b1) begin
                n_fail++; $display("FAIL rnd_grant%0d got g=%b busy=%b exp g=%0d", t, grant_o, busy_o, g); end
            last_g = g;
            pend[g] = 0;
            req_valid_i[g] = 1'b0;
            wait_rsp(n);
            n_tests++; if (n != ref_lat(p_op[g], p_b[g], dit) + 1) begin
                n_fail++; $display("FAIL rnd_latency%0d got=%0d exp=%0d", t, n, ref_lat(p_op[g], p_b[g], dit) + 1); end
            n_tests++; if (rsp_valid_o !== 2'(1 << g) || rsp_result_o !== ref_result(p_op[g], p_sm[g], p_a[g], p_b[g])) begin
                n_fail++; $display("FAIL rnd_result%0d got v=%b r=%h exp r=%h op=%0d", t, rsp_valid_o, rsp_result_o,
                                   ref_result(p_op[g], p_sm[g], p_a[g], p_b[g]), p_op[g]); end
            rsp_ready_i[1 - g] = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            n_tests++; if (rsp_valid_o !== 2'(1 << g)) begin
                n_fail++; $display("FAIL rnd_hold%0d got=%b exp=%0d", t, rsp_valid_o, 1 << g); end
            handshake(g);
        end
        do_reset();
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        req_operator_i = '0;
        req_signed_mode_i = '0;
        req_op_a_i = '0;
        req_op_b_i = '0;
        data_ind_timing_i = 1'b0;
        test_reset();
        test_mull();
        test_simultaneous();
        test_div_zero();
        test_mulh_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
